ws_ctrl: RTL

WS_CTRL -- requirements
Module: ws_ctrl

---
 rtl/ws_pkg.sv | 29 ++
 rtl/ws_ctrl_if.sv | 29 ++
 rtl/ws_region_dec.sv | 18 +
 rtl/ws_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ws_pkg.sv
// Shared types and wait-state constants for the FSB wait-state controller.
package ws_pkg;

    typedef enum logic [1:0] {REG_RAM, REG_ROM, REG_IO} ws_region_e;
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} ws_state_e;

    localparam logic [4:0] WS_RAM        = 5'd2;
    localparam logic [4:0] WS_ROM        = 5'd3;
    localparam logic [4:0] WS_IO         = 5'd7;
    localparam logic [4:0] WS_SLOW_EXTRA = 5'd16;
    localparam logic [7:0] SLOW_RELOAD   = 8'd255;

    typedef struct packed {
        ws_state_e  state;
        ws_region_e region;
        logic       write;
        logic [4:0] cnt;
    } ws_dbg_t;

    function automatic logic [4:0] wait_count(input ws_region_e r, input logic romws,
                                              input logic ramws, input logic iows);
        case (r)
            REG_RAM: return ramws ? WS_RAM : 5'd0;
            REG_ROM: return romws ? WS_ROM : 5'd0;
            default: return iows ? WS_IO : 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/ws_ctrl_if.sv
// FSB-side signal bundle for ws_ctrl; master = bus master/bench, slave = controller.
interface ws_ctrl_if;
    import ws_pkg::*;

    // Handshake: the master holds nAS_FSB low to request a cycle; the controller
    // drives nDTACK_FSB low once the wait count expires and keeps it low until
    // it samples nAS_FSB high. Releasing nAS_FSB before the acknowledge aborts.
    logic       nAS_FSB;
    logic       nWE_FSB;
    logic [3:0] A_FSB;
    logic       ROMWS;
    logic       RAMWS;
    logic       IOWS;
    logic       nDTACK_FSB;
    logic       SlowdownIOWriteGate;
    logic       Busy;
    ws_dbg_t    dbg;

    modport master (
        output nAS_FSB, nWE_FSB, A_FSB, ROMWS, RAMWS, IOWS,
        input  nDTACK_FSB, SlowdownIOWriteGate, Busy, dbg
    );

    modport slave (
        input  nAS_FSB, nWE_FSB, A_FSB, ROMWS, RAMWS, IOWS,
        output nDTACK_FSB, SlowdownIOWriteGate, Busy, dbg
    );

endinterface

// File: rtl/ws_region_dec.sv
// Combinational decode of FSB address bits [23:20] into RAM/ROM/IO regions.
module ws_region_dec
    import ws_pkg::*;
(
    input  logic [3:0] A_FSB,
    output ws_region_e region
);

    always_comb begin
        if (A_FSB[3:2] == 2'b00)
            region = REG_RAM;
        else if (A_FSB == 4'b0100)
            region = REG_ROM;
        else
            region = REG_IO;
    end

endmodule

// File: rtl/ws_ctrl.sv
// FSB wait-state controller: counts per-region waits, then acknowledges via nDTACK_FSB.
// Optional IO-write slowdown window compiled in with WS_CTRL_IO_SLOWDOWN_EN.
module ws_ctrl
    import ws_pkg::*;
(
    input  logic    FCLK,
    input  logic    nRES,
    ws_ctrl_if.slave bus
);

    ws_state_e  state, state_next;
    ws_region_e region, region_q;
    logic       wr_q;
    logic [4:0] cnt;
    logic [4:0] base_wait, start_wait;
    logic       guard;
    logic       dtack_q;
    logic       busy;
    logic       slow_gate;
    ws_dbg_t    dbg;

    ws_region_dec u_dec (.A_FSB(bus.A_FSB), .region(region));

    always_comb base_wait = wait_count(region, bus.ROMWS, bus.RAMWS, bus.IOWS);

`ifdef WS_CTRL_IO_SLOWDOWN_EN
    logic [7:0] slow_cnt, slow_next;
    logic       gate_q;
    logic       io_wr_ack;

    always_comb io_wr_ack = (state == ST_WAIT) && (state_next == ST_ACK)
                            && (region_q == REG_IO) && wr_q;

    always_comb begin
        slow_next = slow_cnt;
        if (io_wr_ack)
            slow_next = SLOW_RELOAD;
        else if (slow_cnt != 8'd0)
            slow_next = slow_cnt - 8'd1;
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            slow_cnt <= 8'd0;
            gate_q   <= 1'b0;
        end else begin
            slow_cnt <= slow_next;
            gate_q   <= (slow_next != 8'd0);
        end
    end

    // An IO write issued inside the window gets the extra waits on top of its own.
    always_comb start_wait = base_wait +
        (((region == REG_IO) && !bus.nWE_FSB && gate_q) ? WS_SLOW_EXTRA : 5'd0);
    assign slow_gate = gate_q;
`else
    always_comb start_wait = base_wait;
    assign slow_gate = 1'b0;
`endif

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // guard is set after reset and after each completed cycle, so a strobe still
    // held low at the next IDLE edge parks in HOLD instead of starting again.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (!bus.nAS_FSB) state_next = guard ? ST_HOLD : ST_WAIT;
            ST_WAIT: begin
                if (bus.nAS_FSB)
                    state_next = ST_IDLE;
                else if (cnt == 5'd0)
                    state_next = ST_ACK;
            end
            ST_ACK:  if (bus.nAS_FSB) state_next = ST_IDLE;
            ST_HOLD: if (bus.nAS_FSB) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge FCLK or negedge nRES) begin
        if (!nRES) begin
            cnt      <= 5'd0;
            region_q <= REG_RAM;
            wr_q     <= 1'b0;
            guard    <= 1'b1;
            dtack_q  <= 1'b1;
        end else begin
            dtack_q <= (state_next != ST_ACK);
            case (state)
                ST_IDLE: begin
                    guard <= 1'b0;
                    if (state_next == ST_WAIT) begin
                        cnt      <= start_wait;
                        region_q <= region;
                        wr_q     <= !bus.nWE_FSB;
                    end
                end
                ST_WAIT: begin
                    if (bus.nAS_FSB)
                        cnt <= 5'd0;
                    else if (cnt != 5'd0)
                        cnt <= cnt - 5'd1;
                end
                ST_ACK: if (state_next == ST_IDLE) guard <= 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        busy       = (state != ST_IDLE);
        dbg.state  = state;
        dbg.region = region_q;
        dbg.write  = wr_q;
        dbg.cnt    = cnt;
    end

    assign bus.nDTACK_FSB          = dtack_q;
    assign bus.SlowdownIOWriteGate = slow_gate;
    assign bus.Busy                = busy;
    assign bus.dbg                 = dbg;

endmodule
